// File: rtl/layer_argmax.sv
// -----------------------------------------------------------------------------
// layer_argmax
//
// Class-decision stage after the final fully-connected layer of the ECG
// classifier. Captures the whole vector of ReLU'd single-precision neuron
// outputs in one cycle, then walks it one element per cycle and keeps the
// largest element seen so far. The winner (index and float bit pattern) is
// offered to the consumer over a valid/ready handshake.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst_n      - asynchronous active-low reset
//   start      - single-cycle request to capture vec_in and begin a scan
//   vec_in     - N_IN packed floats, element i at bits [32*i+31 : 32*i]
//   busy       - high from the start-accept edge until the result is consumed
//   out_valid  - result available on max_idx / max_val
//   out_ready  - consumer accepts the result (only looked at while holding)
//   max_idx    - index of the largest element
//   max_val    - float bit pattern of the largest element
// -----------------------------------------------------------------------------
module layer_argmax #(
   parameter int N_IN  = 32,
   parameter int IDX_W = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [N_IN*32-1:0]   vec_in,
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [IDX_W-1:0]     max_idx,
   output logic [31:0]          max_val
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

   // Strict a > b on IEEE-754 bit patterns using a sign-magnitude rule.
   // +0 and -0 are treated as equal; NaN/Inf get no special handling.
   function automatic logic float_gt(input logic [31:0] a, input logic [31:0] b);
      logic both_zero;
      logic gt;
      both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
      case ({a[31], b[31]})
         2'b00:   gt = a[30:0] > b[30:0];
         2'b11:   gt = a[30:0] < b[30:0];
         2'b01:   gt = 1'b1;
         default: gt = 1'b0;
      endcase
      return gt && !both_zero;
   endfunction

   state_t            state_q, state_d;
   logic [31:0]       vec_q [N_IN];
   logic [31:0]       best_val;
   logic [IDX_W-1:0]  best_idx;
   logic [IDX_W-1:0]  scan_idx;

   logic              accept;
   logic              finish;
   logic              consume;

   logic [31:0]       cand;
   logic              cand_gt;
   logic [31:0]       next_best_val;
   logic [IDX_W-1:0]  next_best_idx;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      finish  = 1'b0;
      consume = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (scan_idx == LAST_IDX) begin
               finish  = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            // start is deliberately not looked at here: a start on the
            // handshake edge is dropped, the next one is taken in IDLE.
            if (out_ready) begin
               consume = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Running compare; only a strictly larger element replaces the current
   // best, which makes ties resolve to the lowest index.
   always_comb begin
      cand          = vec_q[scan_idx];
      cand_gt       = float_gt(cand, best_val);
      next_best_val = cand_gt ? cand     : best_val;
      next_best_idx = cand_gt ? scan_idx : best_idx;
   end

   // NOTE: the captured vector is cleared on reset like every other
   // register, so an aborted scan leaves nothing behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_IN; i++) vec_q[i] <= '0;
         best_val  <= '0;
         best_idx  <= '0;
         scan_idx  <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         max_idx   <= '0;
         max_val   <= '0;
      end else begin
         if (accept) begin
            for (int i = 0; i < N_IN; i++) vec_q[i] <= vec_in[32*i +: 32];
            best_val <= vec_in[31:0];
            best_idx <= '0;
            scan_idx <= IDX_W'(1);
            busy     <= 1'b1;
         end

         if (state_q == SCAN) begin
            best_val <= next_best_val;
            best_idx <= next_best_idx;
            scan_idx <= scan_idx + 1'b1;
         end

         // The final edge publishes the winner including the last compare.
         if (finish) begin
            max_idx   <= next_best_idx;
            max_val   <= next_best_val;
            out_valid <= 1'b1;
         end

         // max_idx / max_val keep their value after the handshake.
         if (consume) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_layer_argmax.sv
module tb_layer_argmax;

   localparam int N_IN  = 32;
   localparam int IDX_W = 5;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               out_ready = 1'b0;
   logic [N_IN*32-1:0] vec_in = '0;
   logic               busy;
   logic               out_valid;
   logic [IDX_W-1:0]   max_idx;
   logic [31:0]        max_val;

   logic [31:0]        elem [N_IN];

   int errors = 0;
   int checks = 0;

   layer_argmax #(.N_IN(N_IN), .IDX_W(IDX_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .vec_in    (vec_in),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .max_idx   (max_idx),
      .max_val   (max_val)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model: map each float onto a signed number line
   // (-magnitude for negatives, so both zeros land on 0) and pick the first
   // index holding the largest value.
   function automatic longint order_key(input logic [31:0] f);
      longint m;
      m = longint'(f[30:0]);
      return f[31] ? -m : m;
   endfunction

   function automatic int model_idx();
      int best;
      best = 0;
      for (int i = 1; i < N_IN; i++)
         if (order_key(elem[i]) > order_key(elem[best])) best = i;
      return best;
   endfunction

   function automatic logic [31:0] int_to_float(input int v);
      int e;
      logic [31:0] mant;
      if (v == 0) return 32'h0;
      e = 0;
      for (int b = 0; b < 31; b++) if (((v >> b) & 1) != 0) e = b;
      mant = (32'(v) << (23 - e)) & 32'h007F_FFFF;
      return {1'b0, 8'(127 + e), mant[22:0]};
   endfunction

   function automatic logic [31:0] rand_float();
      int s, ex;
      logic [31:0] m;
      s  = $urandom_range(0, 1);
      ex = $urandom_range(110, 140);
      m  = $urandom;
      return {s[0], ex[7:0], m[22:0]};
   endfunction

   task automatic apply_elems();
      for (int i = 0; i < N_IN; i++) vec_in[32*i +: 32] = elem[i];
   endtask

   task automatic scramble_vec_in();
      for (int i = 0; i < N_IN; i++) vec_in[32*i +: 32] = $urandom;
   endtask

   // Count edges from the accept edge until out_valid, then check the result.
   task automatic wait_result(input string tag, input int exp_idx, input logic [31:0] exp_val);
      int cycles;
      cycles = 0;
      while (!out_valid && cycles < 100) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      check({tag, ":latency"}, 32'(cycles), 32'(N_IN - 1));
      check({tag, ":idx"}, 32'(max_idx), 32'(exp_idx));
      check({tag, ":val"}, max_val, exp_val);
      check({tag, ":busy"}, 32'(busy), 32'd1);
   endtask

   task automatic run_scan(input string tag);
      int exp_idx;
      exp_idx = model_idx();
      @(negedge clk);
      apply_elems();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      scramble_vec_in();   // must not disturb the captured vector
      wait_result(tag, exp_idx, elem[exp_idx]);
   endtask

   task automatic consume(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, ":valid_after_hs"}, 32'(out_valid), 32'd0);
      check({tag, ":busy_after_hs"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [IDX_W-1:0] held_idx;
      logic [31:0]      held_val;
      int               exp_idx;

      // Reset state
      #12;
      check("rst:busy", 32'(busy), 32'd0);
      check("rst:valid", 32'(out_valid), 32'd0);
      check("rst:idx", 32'(max_idx), 32'd0);
      check("rst:val", max_val, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Ramp: element i = float(i)
      for (int i = 0; i < N_IN; i++) elem[i] = int_to_float(i);
      check("ramp:elem31_bits", elem[31], 32'h41F8_0000);
      run_scan("ramp");
      check("ramp:abs_idx", 32'(max_idx), 32'd31);
      consume("ramp");

      // All equal 1.0: lowest index wins the tie
      for (int i = 0; i < N_IN; i++) elem[i] = 32'h3F80_0000;
      run_scan("tie");
      check("tie:abs_idx", 32'(max_idx), 32'd0);
      consume("tie");

      // All zero
      for (int i = 0; i < N_IN; i++) elem[i] = 32'h0;
      run_scan("zero");
      consume("zero");

      // -0 at index 0, +0 elsewhere: equal, so index 0 stays
      elem[0] = 32'h8000_0000;
      run_scan("signed_zero");
      consume("signed_zero");

      // All negative, -0.1 at index 3 is the least negative
      for (int i = 0; i < N_IN; i++) elem[i] = 32'hBF80_0000 | 32'(i * 1000);
      elem[3] = 32'hBDCC_CCCD;
      run_scan("neg");
      check("neg:abs_idx", 32'(max_idx), 32'd3);
      consume("neg");

      // Mixed signs; leave the result in HOLD for the handshake test
      for (int i = 0; i < N_IN; i++) elem[i] = 32'h8000_0000;
      elem[5] = 32'hBF80_0000;
      elem[9] = 32'h3DCC_CCCD;
      run_scan("mixed");
      check("mixed:abs_idx", 32'(max_idx), 32'd9);

      // HOLD with out_ready low for 10 cycles, start pulse ignored
      held_idx = max_idx;
      held_val = max_val;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 4) begin
            scramble_vec_in();
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         check("hold:valid", 32'(out_valid), 32'd1);
         check("hold:busy", 32'(busy), 32'd1);
         check("hold:idx", 32'(max_idx), 32'(held_idx));
         check("hold:val", max_val, held_val);
      end
      start = 1'b0;

      // Back-to-back: start on the handshake edge is dropped, held for one
      // more edge it is taken; max planted at element 17
      for (int i = 0; i < N_IN; i++) elem[i] = rand_float() & 32'hBFFF_FFFF;
      elem[17] = 32'h42C8_0000;
      exp_idx = model_idx();
      @(negedge clk);
      apply_elems();
      start = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("b2b:valid_after_hs", 32'(out_valid), 32'd0);
      check("b2b:busy_after_hs", 32'(busy), 32'd0);
      check("b2b:idx_retained", 32'(max_idx), 32'd9);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b:busy_accept", 32'(busy), 32'd1);
      wait_result("b2b", exp_idx, elem[exp_idx]);
      check("b2b:abs_idx", 32'(max_idx), 32'd17);
      consume("b2b");

      // Reset in the middle of a scan
      for (int i = 0; i < N_IN; i++) elem[i] = rand_float();
      @(negedge clk);
      apply_elems();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (11) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst:busy", 32'(busy), 32'd0);
      check("midrst:valid", 32'(out_valid), 32'd0);
      check("midrst:idx", 32'(max_idx), 32'd0);
      check("midrst:val", max_val, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < N_IN; i++) elem[i] = int_to_float(N_IN - i);
      run_scan("after_rst");
      consume("after_rst");

      // Randomized vectors with forced ties and zeros
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < N_IN; i++) begin
            elem[i] = rand_float();
            if (i > 0 && $urandom_range(0, 3) == 0) elem[i] = elem[$urandom_range(0, i - 1)];
            if ($urandom_range(0, 15) == 0) elem[i] = {1'($urandom_range(0, 1)), 31'd0};
         end
         run_scan($sformatf("rand%0d", t));
         consume($sformatf("rand%0d", t));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
